header_framer: RTL and testbench
================================

# header_framer

Transmit-side counterpart of the `deframer`. It takes a stream of quantized pixels, packs `PackedNum` pixels into each bus byte, and prefixes every frame with the two header bytes the `deframer` searches for. Its output is a byte stream that the `deframer` accepts unchanged. It sits in front of the UART TX path, or feeds the `deframer` directly for on-chip loopback and self-test without the ESP host.

## Interface
- `UnpackedWidth`, default 1: bits per pixel element.
- `PackedNum`, default 8: elements per output byte; `UnpackedWidth*PackedNum` must equal `BusWidth`.
- `BusWidth`, default 8: output byte width.
- `PacketLenElems`, default 76800: elements per frame; must be a multiple of `PackedNum`.
- `HeaderByte0`, default 8'hA5: first header byte.
- `HeaderByte1`, default 8'h5A: second header byte.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `unpacked_i`  in  UnpackedWidth  pixel element.
- `valid_i`  in  1  element valid.
- `ready_o`  out  1  element accepted when `valid_i & ready_o`.
- `data_o`  out  BusWidth  output byte: header or packed payload.
- `valid_o`  out  1  output byte valid.
- `ready_i`  in  1  downstream accepts the byte when `valid_o & ready_i`.

## Operation
- A single output register holds `data_o` and `valid_o`. Header bytes and payload bytes both load into it.
- The register may load when it is empty (`!valid_o`) or draining (`valid_o & ready_i`). This condition is called "free" below.
- FSM states: HDR0, HDR1, PAYLOAD.
  - HDR0: when free, load `HeaderByte0` and go to HDR1. `ready_o` = 0.
  - HDR1: when free, load `HeaderByte1` and go to PAYLOAD. `ready_o` = 0.
  - PAYLOAD: accept elements into the pack register.
- Pack register layout is LSB-first: element k of a byte occupies bits `[k*UnpackedWidth +: UnpackedWidth]`.
- Slot counter runs 0..PackedNum-1.
- Element counter runs 0..PacketLenElems-1 and is `$clog2(PacketLenElems)` bits wide.
- In PAYLOAD, `ready_o` = (slot != PackedNum-1) | free.
  - The final element of a byte is only accepted when the completed byte can load into the output register in the same cycle.
- Accepting the final element of a byte loads the completed byte: the pack register contents with the incoming element merged into the top slot. The slot counter wraps to 0.
- Accepting element PacketLenElems-1:
  - loads the final byte;
  - clears both counters;
  - moves the FSM to HDR0.
- The next frame's header loads as soon as the output register is free. There is no gap requirement between frames.
- No element is dropped or duplicated. Output bytes per frame = 2 + PacketLenElems/PackedNum.
- While `valid_o & !ready_i`, `data_o` and `valid_o` hold stable.
- `valid_o` falls only on a handshake when nothing is loaded in the same cycle.
- Mid-operation reset clears everything asynchronously. The partially packed byte and the partial frame are discarded. The next frame starts with the header.

## Timing
- Reset values:
  - `valid_o` = 0, `data_o` = 0, `ready_o` = 0;
  - FSM = HDR0;
  - slot and element counters = 0;
  - pack register = 0.
- First clock edge after reset release: `HeaderByte0` is presented with `valid_o` = 1.
- Header emission: with `ready_i` held high, the two header bytes appear on consecutive cycles.
- PAYLOAD starts the cycle after `HeaderByte1` loads.
- Latency: a packed byte appears on `data_o` the cycle after its last element is accepted.
- Throughput: one element per cycle sustained while `ready_i` = 1.
- Simultaneous events:
  - Output handshake and new load in the same cycle: the new byte replaces the old one with `valid_o` staying high (back-to-back bytes).
  - Last element of a frame with `ready_i` = 1: `HeaderByte0` of the next frame loads one cycle after the final byte.
- `ready_o` is combinational from the state, the slot counter, `valid_o` and `ready_i`. There is no combinational path from `valid_i` to `ready_o`.

## Test plan
Test configuration: PacketLenElems=16, UnpackedWidth=1, PackedNum=8, unless a scenario states otherwise.

- **Reset and header:** release reset with `ready_i`=1 and `valid_i`=0 → `data_o` shows A5 then 5A on consecutive cycles, then `valid_o`=0 and `ready_o`=1.
- **Frame packing:** stream 16 elements with 1,0,0,0,0,0,0,0 for byte 0 and all ones for byte 1, `ready_i`=1 → output sequence A5, 5A, 01, FF, then A5 for the next frame.
- **Backpressure:** hold `ready_i`=0 for 5 cycles while presenting the 8th element of a byte → `ready_o`=0 on that slot and `data_o` stable throughout. After `ready_i` rises, the byte completes with no element lost.
- **Randomized handshakes:** toggle `valid_i` and `ready_i` randomly for 3 frames with random pixels → the byte stream, fed through the `deframer`, reproduces the input pixels exactly, 2 bytes per frame per header.
- **Reset mid-frame:** assert `rst_i` after 11 elements → outputs drop to reset values immediately. After release, the stream restarts with A5, 5A and the old partial byte is never emitted.
- **Multi-bit packing:** UnpackedWidth=2, PackedNum=4, elements 3,0,1,2 → payload byte 8'b10_01_00_11 = 0x93.

Source files
------------

// File: rtl/header_framer.sv
// header_framer: prefixes each frame with two header bytes and packs
// PackedNum pixel elements (LSB-first) into each output byte.
module header_framer #(
    parameter int unsigned UnpackedWidth  = 1,
    parameter int unsigned PackedNum      = 8,
    parameter int unsigned BusWidth       = 8,
    parameter int unsigned PacketLenElems = 76800,
    parameter logic [BusWidth-1:0] HeaderByte0 = 8'hA5,
    parameter logic [BusWidth-1:0] HeaderByte1 = 8'h5A
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [UnpackedWidth-1:0] unpacked_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [BusWidth-1:0]      data_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    localparam int unsigned SlotW  = (PackedNum > 1) ? $clog2(PackedNum) : 1;
    localparam int unsigned ElemW  = (PacketLenElems > 1) ? $clog2(PacketLenElems) : 1;
    localparam int unsigned TopLsb = (PackedNum - 1) * UnpackedWidth;
    localparam logic [SlotW-1:0] LastSlot = SlotW'(PackedNum - 1);
    localparam logic [ElemW-1:0] LastElem = ElemW'(PacketLenElems - 1);

    typedef enum logic [1:0] {
        HDR0,
        HDR1,
        PAYLOAD
    } state_t;

    state_t              state_q, state_d;
    logic [SlotW-1:0]    slot_q, slot_d;
    logic [ElemW-1:0]    elem_q, elem_d;
    logic [BusWidth-1:0] pack_q, pack_d;
    logic [BusWidth-1:0] merged;
    logic [BusWidth-1:0] load_data;
    logic                load;
    logic                free;
    logic                accept;

    // Output register can take a new byte when empty or draining this cycle
    always_comb begin
        free    = !valid_o || ready_i;
        ready_o = (state_q == PAYLOAD) && ((slot_q != LastSlot) || free);
        accept  = valid_i && ready_o;
        merged  = pack_q;
        merged[TopLsb +: UnpackedWidth] = unpacked_i;
    end

    // Next-state, counter and pack-register logic
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        elem_d    = elem_q;
        pack_d    = pack_q;
        load      = 1'b0;
        load_data = '0;
        case (state_q)
            HDR0: begin
                if (free) begin
                    load      = 1'b1;
                    load_data = HeaderByte0;
                    state_d   = HDR1;
                end
            end
            HDR1: begin
                if (free) begin
                    load      = 1'b1;
                    load_data = HeaderByte1;
                    state_d   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (slot_q == LastSlot) begin
                        load      = 1'b1;
                        load_data = merged;
                        slot_d    = '0;
                        pack_d    = '0;
                    end else begin
                        pack_d[slot_q*UnpackedWidth +: UnpackedWidth] = unpacked_i;
                        slot_d = slot_q + 1'b1;
                    end
                    if (elem_q == LastElem) begin
                        elem_d  = '0;
                        slot_d  = '0;
                        state_d = HDR0;
                    end else begin
                        elem_d = elem_q + 1'b1;
                    end
                end
            end
            default: state_d = HDR0;
        endcase
    end

    // State, counters and pack register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HDR0;
            slot_q  <= '0;
            elem_q  <= '0;
            pack_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            elem_q  <= elem_d;
            pack_q  <= pack_d;
        end
    end

    // Output register: load replaces a draining byte, otherwise a handshake empties it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (load) begin
            data_o  <= load_data;
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_header_framer.sv
// tb_header_framer: directed checks of header emission, packing,
// backpressure, random handshakes, mid-frame reset and multi-bit packing.
module tb_header_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_i;
    logic       din;
    logic       ready_i;
    logic [7:0] data;
    logic       valid_o;
    logic       ready_o;

    logic       m_vin;
    logic [1:0] m_din;
    logic       m_rdy_o;
    logic [7:0] m_data;
    logic       m_vout;
    logic       m_rdy_i = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [7:0] out_q[$];
    logic       acc_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    header_framer #(
        .UnpackedWidth(1), .PackedNum(8), .BusWidth(8), .PacketLenElems(16),
        .HeaderByte0(8'hA5), .HeaderByte1(8'h5A)
    ) dut (
        .clk_i(clk), .rst_i(rst), .unpacked_i(din), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data), .valid_o(valid_o), .ready_i(ready_i)
    );

    header_framer #(
        .UnpackedWidth(2), .PackedNum(4), .BusWidth(8), .PacketLenElems(8),
        .HeaderByte0(8'hA5), .HeaderByte1(8'h5A)
    ) dut_m (
        .clk_i(clk), .rst_i(rst), .unpacked_i(m_din), .valid_i(m_vin),
        .ready_o(m_rdy_o), .data_o(m_data), .valid_o(m_vout), .ready_i(m_rdy_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag);
        int n;
        check($sformatf("%s_len", tag), out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_b%0d", tag, i), {24'd0, out_q[i]}, {24'd0, exp_q[i]});
    endtask

    // Handshakes seen at the falling edge complete on the following rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) out_q.push_back(data);
            if (valid_i && ready_o) acc_q.push_back(din);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0]  pat;
        logic [7:0]   pa, pb, acc_byte;
        logic [47:0]  px;
        int           idx, cyc;
        logic         hs;
        int unsigned  e1[4];
        int unsigned  e2[4];

        rst = 1'b1; valid_i = 1'b0; din = 1'b0; ready_i = 1'b1;
        m_vin = 1'b0; m_din = '0;

        // Reset and header
        repeat (3) tick();
        check("rst_valid", valid_o, 0);
        check("rst_data", data, 0);
        check("rst_ready", ready_o, 0);
        rst = 1'b0;
        tick();
        check("hdr0_data", data, 8'hA5);
        check("hdr0_valid", valid_o, 1);
        tick();
        check("hdr1_data", data, 8'h5A);
        check("hdr1_valid", valid_o, 1);
        tick();
        check("idle_valid", valid_o, 0);
        check("idle_ready", ready_o, 1);

        // Frame packing
        out_q.delete(); acc_q.delete();
        pat = 16'hFF01;
        for (int i = 0; i < 16; i++) begin
            valid_i = 1'b1;
            din = pat[i];
            tick();
            if (i == 7) check("pack_b0", data, 8'h01);
            if (i == 15) check("pack_b1", data, 8'hFF);
        end
        valid_i = 1'b0;
        tick();
        check("next_hdr0", data, 8'hA5);
        repeat (3) tick();
        exp_q = '{8'h01, 8'hFF, 8'hA5, 8'h5A};
        check_stream("frame");

        // Backpressure on the last slot of a byte
        out_q.delete(); acc_q.delete();
        pa = 8'hD6;
        pb = 8'hD3;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            din = pa[i];
            tick();
        end
        check("bp_a", data, 8'hD6);
        ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            din = pb[i];
            tick();
        end
        din = pb[7];
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_ready%0d", k), ready_o, 0);
            check($sformatf("bp_hold%0d", k), data, 8'hD6);
            check($sformatf("bp_valid%0d", k), valid_o, 1);
            tick();
        end
        ready_i = 1'b1;
        tick();
        check("bp_b", data, 8'hD3);
        valid_i = 1'b0;
        tick();
        check("bp_hdr", data, 8'hA5);
        repeat (3) tick();
        exp_q = '{8'hD6, 8'hD3, 8'hA5, 8'h5A};
        check_stream("bp");
        check("bp_acc_len", acc_q.size(), 16);
        if (acc_q.size() == 16) begin
            for (int i = 0; i < 8; i++) acc_byte[i] = acc_q[i];
            check("bp_acc_a", acc_byte, 8'hD6);
            for (int i = 0; i < 8; i++) acc_byte[i] = acc_q[8 + i];
            check("bp_acc_b", acc_byte, 8'hD3);
        end

        // Randomized handshakes over three frames
        out_q.delete(); acc_q.delete();
        px[31:0]  = $urandom;
        px[47:32] = 16'($urandom);
        idx = 0;
        cyc = 0;
        while (idx < 48 && cyc < 3000) begin
            valid_i = ($urandom_range(0, 3) != 0);
            din     = px[idx];
            ready_i = 1'($urandom_range(0, 1));
            #1;
            hs = valid_i && ready_o;
            tick();
            if (hs) idx++;
            cyc++;
        end
        check("rand_done", idx, 48);
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (20) tick();
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(px[f*16 +: 8]);
            exp_q.push_back(px[f*16 + 8 +: 8]);
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h5A);
        end
        check_stream("rand");
        check("rand_acc_len", acc_q.size(), 48);

        // Reset mid-frame
        out_q.delete(); acc_q.delete();
        ready_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            valid_i = 1'b1;
            din = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        check("mid_acc_len", acc_q.size(), 11);
        check("mid_pre_valid", valid_o, 1);
        check("mid_pre_data", data, 8'hFF);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_ready", ready_o, 0);
        check("mid_rst_m_valid", m_vout, 0);
        tick();
        tick();
        out_q.delete();
        rst = 1'b0;
        ready_i = 1'b1;
        repeat (4) tick();
        pat = 16'h5500;
        for (int i = 0; i < 16; i++) begin
            valid_i = 1'b1;
            din = pat[i];
            tick();
        end
        valid_i = 1'b0;
        repeat (4) tick();
        exp_q = '{8'hA5, 8'h5A, 8'h00, 8'h55, 8'hA5, 8'h5A};
        check_stream("mid");

        // Multi-bit packing on the 2-bit instance
        e1 = '{3, 0, 1, 2};
        e2 = '{2, 2, 2, 2};
        check("m_ready", m_rdy_o, 1);
        for (int i = 0; i < 4; i++) begin
            m_vin = 1'b1;
            m_din = 2'(e1[i]);
            tick();
        end
        check("m_b0", m_data, 8'h93);
        check("m_b0_valid", m_vout, 1);
        for (int i = 0; i < 4; i++) begin
            m_din = 2'(e2[i]);
            tick();
        end
        check("m_b1", m_data, 8'hAA);
        m_vin = 1'b0;
        tick();
        check("m_hdr0", m_data, 8'hA5);
        tick();
        check("m_hdr1", m_data, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
